// File: rtl/irrigation_sequencer_if.sv
// Signal bundle between the irrigation decision logic and the sequencer.
// The sequencer sits on the slave side; the driving environment uses master.
interface irrigation_sequencer_if;
  logic       tick;
  logic       irrigation_on;
  logic       splinker_mode_on;
  logic       conflicting_values;
  logic       low_water_level;
  logic       high_water_level;
  logic       pulse;
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic       water_supply_valvule;
  logic       alarm;
  logic [2:0] sequencer_state;

  modport slave (
    input  tick,
    input  irrigation_on,
    input  splinker_mode_on,
    input  conflicting_values,
    input  low_water_level,
    input  high_water_level,
    input  pulse,
    output splinker_bomb,
    output dripper_valvule,
    output water_supply_valvule,
    output alarm,
    output sequencer_state
  );

  modport master (
    output tick,
    output irrigation_on,
    output splinker_mode_on,
    output conflicting_values,
    output low_water_level,
    output high_water_level,
    output pulse,
    input  splinker_bomb,
    input  dripper_valvule,
    input  water_supply_valvule,
    input  alarm,
    input  sequencer_state
  );
endinterface

// File: rtl/irrigation_sequencer.sv
// Timed irrigation sequencer: debounce, mode latch, min/max run, cooldown,
// refill timeout supervision and latched fault with acknowledge.
//
//   state        | meaning
//   IDLE         | waiting for an irrigation request
//   ARMING       | debouncing the request
//   RUN_SPLINKER | sprinkler pump on
//   RUN_DRIPPER  | dripper valve on
//   COOLDOWN     | enforced pause after a run, requests ignored
//   FAULT        | sensor conflict or refill timeout, waits for acknowledge
module irrigation_sequencer #(
  parameter int COUNTER_WIDTH        = 8,
  parameter int STABLE_TICKS         = 4,
  parameter int MIN_RUN_TICKS        = 8,
  parameter int MAX_RUN_TICKS        = 60,
  parameter int COOLDOWN_TICKS       = 10,
  parameter int REFILL_TIMEOUT_TICKS = 100
) (
  input logic                   clock,
  input logic                   reset_n,
  irrigation_sequencer_if.slave bus
);

  localparam int CW = COUNTER_WIDTH;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t STABLE_LAST   = CW'(STABLE_TICKS - 1);
  localparam cnt_t RUN_MIN       = CW'(MIN_RUN_TICKS);
  localparam cnt_t RUN_MAX       = CW'(MAX_RUN_TICKS);
  localparam cnt_t RUN_LAST      = CW'(MAX_RUN_TICKS - 1);
  localparam cnt_t COOL_LAST     = CW'(COOLDOWN_TICKS - 1);
  localparam cnt_t REFILL_MAX    = CW'(REFILL_TIMEOUT_TICKS);
  localparam cnt_t REFILL_LAST   = CW'(REFILL_TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'b000,
    ST_ARMING       = 3'b001,
    ST_RUN_SPLINKER = 3'b010,
    ST_RUN_DRIPPER  = 3'b011,
    ST_COOLDOWN     = 3'b100,
    ST_FAULT        = 3'b101
  } state_e;

  state_e state_q, state_d;
  cnt_t   stable_count_q, stable_count_d;
  cnt_t   run_count_q, run_count_d;
  cnt_t   cooldown_count_q, cooldown_count_d;
  cnt_t   refill_count_q, refill_count_d;
  logic   mode_q, mode_d;
  logic   splinker_bomb_q, splinker_bomb_d;
  logic   dripper_valvule_q, dripper_valvule_d;
  logic   water_supply_valvule_q, water_supply_valvule_d;
  logic   alarm_q, alarm_d;
  logic   refill_timeout;
  logic   run_active;

  function automatic cnt_t sat_inc(input cnt_t value, input cnt_t limit);
    return (value >= limit) ? limit : value + 1'b1;
  endfunction

  always_comb begin
    state_d          = state_q;
    stable_count_d   = stable_count_q;
    run_count_d      = run_count_q;
    cooldown_count_d = cooldown_count_q;
    refill_count_d   = refill_count_q;
    mode_d           = mode_q;
    refill_timeout   = 1'b0;

    // Refill time is measured only while the valve is actually open.
    if (bus.high_water_level) begin
      refill_count_d = '0;
    end else if (water_supply_valvule_q && bus.tick) begin
      refill_count_d = sat_inc(refill_count_q, REFILL_MAX);
      refill_timeout = (refill_count_q == REFILL_LAST);
    end

    if (bus.conflicting_values || refill_timeout) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.irrigation_on) begin
            state_d        = ST_ARMING;
            stable_count_d = '0;
          end
        end

        ST_ARMING: begin
          if (!bus.irrigation_on) begin
            state_d        = ST_IDLE;
            stable_count_d = '0;
          end else if (bus.tick) begin
            if (stable_count_q == STABLE_LAST) begin
              mode_d      = bus.splinker_mode_on;
              state_d     = bus.splinker_mode_on ? ST_RUN_SPLINKER : ST_RUN_DRIPPER;
              run_count_d = '0;
            end else begin
              stable_count_d = sat_inc(stable_count_q, STABLE_LAST);
            end
          end
        end

        ST_RUN_SPLINKER, ST_RUN_DRIPPER: begin
          if (bus.tick) begin
            run_count_d = sat_inc(run_count_q, RUN_MAX);
          end
          // Dry-run protection wins over the minimum run time.
          if (!bus.low_water_level ||
              (!bus.irrigation_on && run_count_q >= RUN_MIN) ||
              (bus.tick && run_count_q == RUN_LAST)) begin
            state_d          = ST_COOLDOWN;
            cooldown_count_d = '0;
          end
        end

        ST_COOLDOWN: begin
          if (bus.tick) begin
            if (cooldown_count_q == COOL_LAST) begin
              state_d = ST_IDLE;
            end else begin
              cooldown_count_d = sat_inc(cooldown_count_q, COOL_LAST);
            end
          end
        end

        ST_FAULT: begin
          if (bus.pulse) begin
            state_d          = ST_IDLE;
            stable_count_d   = '0;
            run_count_d      = '0;
            cooldown_count_d = '0;
            refill_count_d   = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    run_active             = (state_d == ST_RUN_SPLINKER) || (state_d == ST_RUN_DRIPPER);
    splinker_bomb_d        = run_active && mode_d;
    dripper_valvule_d      = run_active && !mode_d;
    alarm_d                = (state_d == ST_FAULT);
    water_supply_valvule_d = !bus.high_water_level && !bus.conflicting_values &&
                             (state_d != ST_FAULT);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q                <= ST_IDLE;
      stable_count_q         <= '0;
      run_count_q            <= '0;
      cooldown_count_q       <= '0;
      refill_count_q         <= '0;
      mode_q                 <= 1'b0;
      splinker_bomb_q        <= 1'b0;
      dripper_valvule_q      <= 1'b0;
      water_supply_valvule_q <= 1'b0;
      alarm_q                <= 1'b0;
    end else begin
      state_q                <= state_d;
      stable_count_q         <= stable_count_d;
      run_count_q            <= run_count_d;
      cooldown_count_q       <= cooldown_count_d;
      refill_count_q         <= refill_count_d;
      mode_q                 <= mode_d;
      splinker_bomb_q        <= splinker_bomb_d;
      dripper_valvule_q      <= dripper_valvule_d;
      water_supply_valvule_q <= water_supply_valvule_d;
      alarm_q                <= alarm_d;
    end
  end

  assign bus.splinker_bomb        = splinker_bomb_q;
  assign bus.dripper_valvule      = dripper_valvule_q;
  assign bus.water_supply_valvule = water_supply_valvule_q;
  assign bus.alarm                = alarm_q;
  assign bus.sequencer_state      = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Bench for irrigation_sequencer: directed scenarios then randomized inputs,
// every cycle compared against a tick-counting reference model.
module tb_irrigation_sequencer;

  localparam int STABLE  = 4;
  localparam int MIN_RUN = 8;
  localparam int MAX_RUN = 60;
  localparam int COOL    = 10;
  localparam int REFILL  = 100;

  localparam int S_IDLE = 0, S_ARM = 1, S_RUN_S = 2, S_RUN_D = 3, S_COOL = 4, S_FAULT = 5;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  irrigation_sequencer_if bus_if ();

  irrigation_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed-tick bookkeeping per phase of the irrigation cycle.
  int m_state, m_stable, m_run, m_cool, m_fill;
  bit m_bomb, m_drip, m_valve, m_alarm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {bus_if.sequencer_state, bus_if.splinker_bomb, bus_if.dripper_valvule,
            bus_if.water_supply_valvule, bus_if.alarm};
  endfunction

  function automatic logic [6:0] model_outs();
    logic [2:0] st;
    st = 3'(m_state);
    return {st, m_bomb, m_drip, m_valve, m_alarm};
  endfunction

  function automatic void model_step();
    int nxt;
    bit timeout;
    bit ran_min;
    timeout = 1'b0;
    if (!reset_n) begin
      m_state = S_IDLE; m_stable = 0; m_run = 0; m_cool = 0; m_fill = 0;
      m_bomb = 0; m_drip = 0; m_valve = 0; m_alarm = 0;
      return;
    end
    if (bus_if.high_water_level) m_fill = 0;
    else if (m_valve && bus_if.tick) begin
      m_fill++;
      timeout = (m_fill == REFILL);
    end
    nxt = m_state;
    if (bus_if.conflicting_values || timeout) nxt = S_FAULT;
    else if (m_state == S_IDLE) begin
      if (bus_if.irrigation_on) begin nxt = S_ARM; m_stable = 0; end
    end else if (m_state == S_ARM) begin
      if (!bus_if.irrigation_on) nxt = S_IDLE;
      else if (bus_if.tick) begin
        m_stable++;
        if (m_stable == STABLE) begin
          nxt   = bus_if.splinker_mode_on ? S_RUN_S : S_RUN_D;
          m_run = 0;
        end
      end
    end else if (m_state == S_RUN_S || m_state == S_RUN_D) begin
      ran_min = (m_run >= MIN_RUN);
      if (bus_if.tick) m_run++;
      if (!bus_if.low_water_level || (!bus_if.irrigation_on && ran_min) || m_run == MAX_RUN) begin
        nxt = S_COOL; m_cool = 0;
      end
    end else if (m_state == S_COOL) begin
      if (bus_if.tick) begin
        m_cool++;
        if (m_cool == COOL) nxt = S_IDLE;
      end
    end else if (m_state == S_FAULT) begin
      if (bus_if.pulse) begin
        nxt = S_IDLE; m_stable = 0; m_run = 0; m_cool = 0; m_fill = 0;
      end
    end
    m_state = nxt;
    m_bomb  = (nxt == S_RUN_S);
    m_drip  = (nxt == S_RUN_D);
    m_alarm = (nxt == S_FAULT);
    m_valve = !bus_if.high_water_level && !bus_if.conflicting_values && (nxt != S_FAULT);
  endfunction

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus_if.tick = 1'b1;
      cycle();
      bus_if.tick = 1'b0;
      cycle();
      cycle();
    end
  endtask

  initial begin
    reset_n                   = 1'b0;
    bus_if.tick               = 1'b1;
    bus_if.irrigation_on      = 1'b1;
    bus_if.splinker_mode_on   = 1'b1;
    bus_if.conflicting_values = 1'b1;
    bus_if.low_water_level    = 1'b1;
    bus_if.high_water_level   = 1'b1;
    bus_if.pulse              = 1'b1;
    cycle();
    cycle();
    check_eq("rst_outs", 32'(dut_outs()), 32'h0);

    reset_n                   = 1'b1;
    bus_if.conflicting_values = 1'b0;
    bus_if.pulse              = 1'b0;
    bus_if.tick               = 1'b0;
    cycle();
    check_eq("rel_arming", 32'(dut_outs()), 32'(7'b001_0000));

    ticks(4);
    check_eq("deb_run", 32'(dut_outs()), 32'(7'b010_1000));

    ticks(3);
    bus_if.irrigation_on = 1'b0;
    ticks(4);
    check_eq("min_hold", 32'(dut_outs()), 32'(7'b010_1000));
    ticks(1);
    check_eq("min_exit", 32'(dut_outs()), 32'(7'b100_0000));
    ticks(9);
    check_eq("cool_hold", 32'(dut_outs()), 32'(7'b100_0000));
    ticks(1);
    check_eq("cool_done", 32'(dut_outs()), 32'h0);

    bus_if.irrigation_on = 1'b1;
    cycle();
    ticks(2);
    bus_if.irrigation_on = 1'b0;
    cycle();
    check_eq("abort_idle", 32'(dut_outs()), 32'h0);

    bus_if.irrigation_on = 1'b1;
    cycle();
    ticks(4);
    ticks(59);
    check_eq("max_hold", 32'(dut_outs()), 32'(7'b010_1000));
    ticks(1);
    check_eq("max_exit", 32'(dut_outs()), 32'(7'b100_0000));
    bus_if.irrigation_on = 1'b0;
    ticks(10);

    bus_if.splinker_mode_on = 1'b0;
    bus_if.irrigation_on    = 1'b1;
    cycle();
    ticks(4);
    check_eq("drip_run", 32'(dut_outs()), 32'(7'b011_0100));
    bus_if.splinker_mode_on = 1'b1;
    ticks(1);
    check_eq("mode_lock", 32'(dut_outs()), 32'(7'b011_0100));
    ticks(1);
    bus_if.low_water_level = 1'b0;
    cycle();
    check_eq("dry_exit", 32'(dut_outs()), 32'(7'b100_0000));
    bus_if.low_water_level = 1'b1;
    bus_if.irrigation_on   = 1'b0;
    ticks(10);

    bus_if.high_water_level = 1'b0;
    cycle();
    check_eq("fill_open", 32'(dut_outs()), 32'(7'b000_0010));
    ticks(99);
    check_eq("fill_hold", 32'(dut_outs()), 32'(7'b000_0010));
    ticks(1);
    check_eq("fill_timeout", 32'(dut_outs()), 32'(7'b101_0001));
    bus_if.high_water_level = 1'b1;
    bus_if.pulse            = 1'b1;
    cycle();
    check_eq("fill_ack", 32'(dut_outs()), 32'h0);
    bus_if.pulse = 1'b0;

    bus_if.irrigation_on = 1'b1;
    cycle();
    ticks(6);
    bus_if.conflicting_values = 1'b1;
    cycle();
    check_eq("conf_fault", 32'(dut_outs()), 32'(7'b101_0001));
    bus_if.pulse = 1'b1;
    cycle();
    check_eq("conf_pulse_ignored", 32'(dut_outs()), 32'(7'b101_0001));
    bus_if.conflicting_values = 1'b0;
    cycle();
    check_eq("conf_ack", 32'(dut_outs()), 32'h0);
    bus_if.pulse         = 1'b0;
    bus_if.irrigation_on = 1'b0;
    cycle();

    for (int i = 0; i < 6000; i++) begin
      reset_n     = ($urandom_range(0, 999) != 0);
      bus_if.tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) bus_if.irrigation_on = ~bus_if.irrigation_on;
      if ($urandom_range(0, 7) == 0) bus_if.splinker_mode_on = ~bus_if.splinker_mode_on;
      if (bus_if.conflicting_values) bus_if.conflicting_values = ($urandom_range(0, 3) != 0);
      else bus_if.conflicting_values = ($urandom_range(0, 299) == 0);
      if (bus_if.low_water_level) bus_if.low_water_level = ($urandom_range(0, 99) != 0);
      else bus_if.low_water_level = ($urandom_range(0, 9) == 0);
      if (bus_if.high_water_level) bus_if.high_water_level = ($urandom_range(0, 99) != 0);
      else bus_if.high_water_level = ($urandom_range(0, 149) == 0);
      bus_if.pulse = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
